i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter ADDRESS, default 7'h4a, 7-bit I2C device address the block responds to.
REQ-002 clk  input  1  system clock; SCL and SDA are oversampled in this domain.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sda  inout  1  I2C data, open-drain: block drives 0 or high-Z only, never 1.
REQ-005 scl  input  1  I2C clock from master (no clock stretching).
REQ-006 csr_a  output  5  register address for both read and write accesses.
REQ-007 csr_di  input  8  register read data, combinational from csr_a.
REQ-008 csr_we  output  1  single-clk write strobe.
REQ-009 csr_do  output  8  register write data, valid while csr_we=1 and held afterwards.

Function
REQ-010 SCL and SDA shall pass through 2-FF synchronisers; all protocol decisions use synchronised levels and SCL rise/fall edge strobes.
REQ-011 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both detected in any state.
REQ-012 START, including repeated START, shall enter ADDR state and release SDA; STOP shall enter IDLE and release SDA.
REQ-013 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-014 Bits shift in MSB first on SCL rise; SDA output changes only after SCL fall.
REQ-015 ADDR: after 8 bits, if bits[7:1]==ADDRESS, drive ACK (SDA low) from the next SCL fall to the following SCL fall; on mismatch go IDLE without ACK.
REQ-016 R/W bit 0 -> REG state; R/W bit 1 -> RD state.
REQ-017 REG: the first write byte sets csr_a to byte[4:0], with bits [7:5] ignored; the byte is ACKed, then the state goes to WR.
REQ-018 WR: each received byte is ACKed; csr_do=byte; csr_we pulses one clk at the SCL fall after bit 8; csr_a increments one clk after the pulse.
REQ-019 RD: at entry and after each master ACK, csr_di is latched into the shift register at the SCL fall, and the MSB is driven at once.
REQ-020 RD: SDA is released for the ACK bit; the master's SDA is sampled at the 9th SCL rise.
REQ-021 RD: master ACK (0) shall increment csr_a and continue RD; NACK (1) shall leave csr_a unchanged, release SDA, and wait in IDLE.
REQ-022 csr_a increment shall wrap 5'h1f -> 5'h00.
REQ-023 csr_a persists across transactions; a read without a preceding register byte uses the current csr_a.
REQ-024 A START or STOP mid-byte shall abort the byte: no csr_we and no csr_a change.
REQ-025 SCL high and low phases shall each be at least 8 clk periods.

Reset
REQ-026 While rst=0: state IDLE, SDA released, csr_a=0, csr_do=0, csr_we=0, bit counter and shift register 0.
REQ-027 Reset asserted mid-transfer shall take effect immediately, with no csr_we pulse.

Configuration
REQ-028 Macro I2C_SLAVE_GLITCH_FILTER_EN, when defined: each synchronised line changes only after 3 consecutive equal samples, adding 2 clk latency.
REQ-029 Without the macro, synchronised levels are used directly.

Structure
REQ-030 Package i2c_slave_pkg shall hold the state enum, ADDR_W=5, DATA_W=8, and the filter length.
REQ-031 Sub-module i2c_slave_filter shall provide one line's synchroniser, optional glitch filter, and rise/fall strobes; it is instantiated twice.

Verification
REQ-032 Write: START, 0x94 (addr 4a W), 0x1f, 0xaa, 0x55, STOP -> ACK on all bytes; csr_we with csr_a=1f/csr_do=aa, then csr_a=00/csr_do=55; final csr_a=01.
REQ-033 Wrong address: START, 0x96 (addr 4b W), 0x1f, 0xaa, STOP -> no ACK; no csr_we; csr_a unchanged.
REQ-034 Read: csr_di=0x83; START, 0x94, 0x10, repeated START, 0x95, four bytes with master ACK, ACK, NACK, NACK, STOP.
REQ-035 Read response (REQ-034): 0x83 on SDA for 3 bytes; csr_a steps 10->11->12 and stays at 12 after the NACK; the fourth byte gets no drive.
REQ-036 Mid-byte STOP during WR after 4 bits -> no csr_we; the next START is accepted normally.
REQ-037 Reset pulse during an RD byte -> SDA released immediately; all outputs reset.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and sizes for the i2c_slave block.
package i2c_slave_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 8;
   localparam int FILT_LEN = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_ACK
   } state_t;

endpackage

// File: rtl/i2c_slave_filter.sv
// One I2C line: 2-FF synchroniser, optional majority-free glitch filter, edge strobes.
// Glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_filter
   import i2c_slave_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic level_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         level_d <= 1'b1;
      end else begin
         s1      <= din;
         s2      <= s1;
         level_d <= level;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [FILT_LEN-2:0] hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '1;
      end else begin
         hist <= {hist[FILT_LEN-3:0], s2};
      end
   end

   // level follows s2 only once the current and previous samples all agree
   always_comb begin
      level = level_d;
      if (hist == {(FILT_LEN-1){s2}}) level = s2;
   end
`else
   assign level = s2;
`endif

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave bridging master transactions onto a simple 5-bit CSR bus.
// Optional SCL/SDA glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
//
// state       | meaning
// ST_IDLE     | bus ignored until START
// ST_ADDR     | shifting in device address + R/W
// ST_ADDR_ACK | driving ACK for matched address
// ST_REG      | shifting in register address byte
// ST_REG_ACK  | driving ACK for register byte
// ST_WR       | shifting in write data byte
// ST_WR_ACK   | driving ACK for write data
// ST_RD       | shifting out read data byte
// ST_RD_ACK   | sampling master ACK/NACK
module i2c_slave
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] ADDRESS = 7'h4a
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire               sda,
   input  logic              scl,
   output logic [ADDR_W-1:0] csr_a,
   input  logic [DATA_W-1:0] csr_di,
   output logic              csr_we,
   output logic [DATA_W-1:0] csr_do
);

   logic scl_l, scl_rise, scl_fall;
   logic sda_l, sda_rise, sda_fall;
   logic start, stop;

   state_t            state;
   logic [3:0]        bit_cnt;
   logic [DATA_W-1:0] shift;
   logic              sda_oe;
   logic              rw;

   i2c_slave_filter u_scl_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (scl),
      .level (scl_l),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_slave_filter u_sda_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (sda),
      .level (sda_l),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start = sda_fall & scl_l;
   assign stop  = sda_rise & scl_l;
   assign sda   = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         sda_oe  <= 1'b0;
         rw      <= 1'b0;
         csr_a   <= '0;
         csr_do  <= '0;
         csr_we  <= 1'b0;
      end else begin
         csr_we <= 1'b0;
         // address advances the cycle after the write strobe
         if (csr_we) csr_a <= csr_a + 5'd1;

         if (start) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
            shift   <= '0;
            sda_oe  <= 1'b0;
         end else if (stop) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
         end else begin
            if (scl_rise && (state inside {ST_ADDR, ST_REG, ST_WR, ST_RD})) begin
               bit_cnt <= bit_cnt + 4'd1;
               if (state != ST_RD) shift <= {shift[DATA_W-2:0], sda_l};
            end

            case (state)
               ST_ADDR: begin
                  if (scl_fall && bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     if (shift[7:1] == ADDRESS) begin
                        state  <= ST_ADDR_ACK;
                        sda_oe <= 1'b1;
                        rw     <= shift[0];
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (rw) begin
                        state  <= ST_RD;
                        shift  <= csr_di;
                        sda_oe <= ~csr_di[DATA_W-1];
                     end else begin
                        state  <= ST_REG;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               ST_REG: begin
                  if (scl_fall && bit_cnt == 4'd8) begin
                     csr_a   <= shift[ADDR_W-1:0];
                     state   <= ST_REG_ACK;
                     sda_oe  <= 1'b1;
                     bit_cnt <= '0;
                  end
               end
               ST_REG_ACK, ST_WR_ACK: begin
                  if (scl_fall) begin
                     state  <= ST_WR;
                     sda_oe <= 1'b0;
                  end
               end
               ST_WR: begin
                  if (scl_fall && bit_cnt == 4'd8) begin
                     csr_do  <= shift;
                     csr_we  <= 1'b1;
                     state   <= ST_WR_ACK;
                     sda_oe  <= 1'b1;
                     bit_cnt <= '0;
                  end
               end
               ST_RD: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        state   <= ST_RD_ACK;
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                     end else begin
                        shift  <= {shift[DATA_W-2:0], 1'b0};
                        sda_oe <= ~shift[DATA_W-2];
                     end
                  end
               end
               ST_RD_ACK: begin
                  // NACK leaves on the rise, so any fall seen here follows an ACK
                  if (scl_rise) begin
                     if (sda_l) state <= ST_IDLE;
                     else       csr_a <= csr_a + 5'd1;
                  end else if (scl_fall) begin
                     state  <= ST_RD;
                     shift  <= csr_di;
                     sda_oe <= ~csr_di[DATA_W-1];
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed I2C master bench for i2c_slave with a CSR write-strobe scoreboard.
module tb_i2c_slave;

   localparam int H = 200;
   localparam int Q = 100;

   typedef struct packed {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk;
   logic       rst;
   logic       scl;
   logic       m_low;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;
   wire        sda;

   int  checks;
   int  errors;
   wr_t exp_q[$];

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave #(.ADDRESS(7'h4a)) dut (
      .clk    (clk),
      .rst    (rst),
      .sda    (sda),
      .scl    (scl),
      .csr_a  (csr_a),
      .csr_di (csr_di),
      .csr_we (csr_we),
      .csr_do (csr_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every write strobe must match the next queued expectation
   always @(negedge clk) begin
      if (csr_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we: got a=%0h d=%0h expected no strobe", csr_a, csr_do);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("we_addr", {27'd0, csr_a}, {27'd0, e.a});
            check("we_data", {24'd0, csr_do}, {24'd0, e.d});
         end
      end
   end

   task automatic i2c_start();
      m_low = 1'b0; #Q;
      scl = 1'b1;   #H;
      m_low = 1'b1; #H;
      scl = 1'b0;   #Q;
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; #Q;
      scl = 1'b1;   #H;
      m_low = 1'b0; #H;
   endtask

   task automatic write_bit(input logic b);
      m_low = ~b; #Q;
      scl = 1'b1; #H;
      scl = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic b);
      m_low = 1'b0; #Q;
      scl = 1'b1;   #(H/2);
      b = sda;      #(H/2);
      scl = 1'b0;   #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nack);
   endtask

   task automatic wr_ack(input string name, input logic [7:0] d, input logic exp_ack);
      logic ack;
      write_byte(d, ack);
      check(name, {31'd0, ack}, {31'd0, exp_ack});
   endtask

   task automatic rd_chk(input string name, input logic nack, input logic [7:0] exp_d);
      logic [7:0] d;
      read_byte(nack, d);
      check(name, {24'd0, d}, {24'd0, exp_d});
   endtask

   initial begin
      logic b;
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      scl    = 1'b1;
      m_low  = 1'b0;
      csr_di = 8'h83;
      #100;
      check("rst_csr_a", {27'd0, csr_a}, 32'h0);
      check("rst_csr_do", {24'd0, csr_do}, 32'h0);
      check("rst_csr_we", {31'd0, csr_we}, 32'h0);
      check("rst_sda", {31'd0, sda}, 32'h1);
      rst = 1'b1;
      #200;

      // write two bytes starting at register 1f, wrapping to 00
      i2c_start();
      wr_ack("wr_addr_ack", 8'h94, 1'b0);
      wr_ack("wr_reg_ack", 8'h1f, 1'b0);
      check("wr_reg_set", {27'd0, csr_a}, 32'h1f);
      exp_q.push_back('{a: 5'h1f, d: 8'haa});
      wr_ack("wr_d0_ack", 8'haa, 1'b0);
      exp_q.push_back('{a: 5'h00, d: 8'h55});
      wr_ack("wr_d1_ack", 8'h55, 1'b0);
      i2c_stop();
      #H;
      check("wr_drain", exp_q.size(), 0);
      check("wr_final_a", {27'd0, csr_a}, 32'h01);
      check("wr_do_held", {24'd0, csr_do}, 32'h55);

      // wrong device address: nothing acknowledged or written
      i2c_start();
      wr_ack("bad_addr_nack", 8'h96, 1'b1);
      wr_ack("bad_reg_nack", 8'h1f, 1'b1);
      wr_ack("bad_d_nack", 8'haa, 1'b1);
      i2c_stop();
      #H;
      check("bad_a_kept", {27'd0, csr_a}, 32'h01);

      // read with register preset and repeated START
      i2c_start();
      wr_ack("rd_addr_ack", 8'h94, 1'b0);
      wr_ack("rd_reg_ack", 8'h10, 1'b0);
      check("rd_reg_set", {27'd0, csr_a}, 32'h10);
      i2c_start();
      wr_ack("rd_addrr_ack", 8'h95, 1'b0);
      rd_chk("rd_b0", 1'b0, 8'h83);
      check("rd_a_11", {27'd0, csr_a}, 32'h11);
      rd_chk("rd_b1", 1'b0, 8'h83);
      check("rd_a_12", {27'd0, csr_a}, 32'h12);
      rd_chk("rd_b2", 1'b1, 8'h83);
      check("rd_a_nack", {27'd0, csr_a}, 32'h12);
      rd_chk("rd_b3_undriven", 1'b1, 8'hff);
      i2c_stop();
      #H;
      check("rd_a_final", {27'd0, csr_a}, 32'h12);

      // STOP after 4 data bits aborts the byte, next transaction works
      i2c_start();
      wr_ack("ab_addr_ack", 8'h94, 1'b0);
      wr_ack("ab_reg_ack", 8'h05, 1'b0);
      for (int i = 7; i >= 4; i--) write_bit(1'b1 ^ i[0]);
      i2c_stop();
      #H;
      check("ab_a_kept", {27'd0, csr_a}, 32'h05);
      i2c_start();
      wr_ack("ab2_addr_ack", 8'h94, 1'b0);
      wr_ack("ab2_reg_ack", 8'h07, 1'b0);
      exp_q.push_back('{a: 5'h07, d: 8'h3c});
      wr_ack("ab2_d_ack", 8'h3c, 1'b0);
      i2c_stop();
      #H;
      check("ab2_drain", exp_q.size(), 0);
      check("ab2_a", {27'd0, csr_a}, 32'h08);

      // reset while the slave drives a 0 bit of a read byte
      i2c_start();
      wr_ack("rs_addr_ack", 8'h94, 1'b0);
      wr_ack("rs_reg_ack", 8'h10, 1'b0);
      i2c_start();
      wr_ack("rs_addrr_ack", 8'h95, 1'b0);
      read_bit(b);
      check("rs_bit7", {31'd0, b}, 32'h1);
      m_low = 1'b0; #Q;
      scl = 1'b1;   #(H/2);
      check("rs_bit6_drv", {31'd0, sda}, 32'h0);
      rst = 1'b0;
      #1;
      check("rs_sda_rel", {31'd0, sda}, 32'h1);
      check("rs_csr_a", {27'd0, csr_a}, 32'h0);
      check("rs_csr_do", {24'd0, csr_do}, 32'h0);
      check("rs_csr_we", {31'd0, csr_we}, 32'h0);
      #(H/2);
      scl = 1'b0; #Q;
      rst = 1'b1; #Q;
      i2c_stop();
      #H;

      i2c_start();
      wr_ack("post_addr_ack", 8'h94, 1'b0);
      wr_ack("post_reg_ack", 8'h02, 1'b0);
      exp_q.push_back('{a: 5'h02, d: 8'h99});
      wr_ack("post_d_ack", 8'h99, 1'b0);
      i2c_stop();
      #H;
      check("post_drain", exp_q.size(), 0);
      check("post_a", {27'd0, csr_a}, 32'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
